vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is pclk and the reset port is rst.
REQ-002 Parameter H_VISIBLE, default 640, SHALL be the number of visible pixels per line.
REQ-003 Parameter V_VISIBLE, default 480, SHALL be the number of visible lines per frame.
REQ-004 pclk  input  1  pixel clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  pixel-clock-locked qualifier.
REQ-007 col_in  input  10  current column from the timing generator.
REQ-008 row_in  input  10  current row from the timing generator.
REQ-009 hsync_in / vsync_in  input  1 each  active-low syncs from the timing generator.
REQ-010 pat_sel  input  2  requested pattern.
REQ-011 red / green / blue  output  1 each  registered colour.
REQ-012 hsync / vsync  output  1 each  registered, latency-matched syncs.

Function
REQ-013 The datapath SHALL be a 2-stage pipeline: outputs at cycle N+2 SHALL reflect inputs sampled at cycle N, and syncs SHALL be delayed identically to colour.
REQ-014 A pixel SHALL be visible iff col_in < H_VISIBLE and row_in < V_VISIBLE; non-visible pixels SHALL output RGB 000.
REQ-015 The frame boundary SHALL be a falling edge on vsync_in (registered 1 -> 0); only at that boundary SHALL the active pattern latch pat_sel, frame_cnt (8-bit) increment with wrap 255 -> 0, and the box update.
REQ-016 A pat_sel change mid-frame SHALL have no effect until the next frame boundary.
REQ-017 Pattern 0 (bars): bar index k = col_in / 80 (0..7); {red,green,blue} SHALL be 7 - k.
REQ-018 Pattern 1 (checker): white iff ((col_in + frame_cnt) bit 5) XOR (row_in bit 5), else black; the addition is 10-bit and discards carry.
REQ-019 Pattern 2 (grid): white iff col_in[4:0] == 0, row_in[4:0] == 0, col_in == H_VISIBLE-1 or row_in == V_VISIBLE-1, else blue (001).
REQ-020 Pattern 3 (box): red (100) iff bx <= col_in < bx+64 and by <= row_in < by+64, else black.
REQ-021 Box FSM SHALL use per-axis direction states INC/DEC, and each frame boundary SHALL move each axis by 1.
REQ-022 X axis: at bx == H_VISIBLE-64 (576) in INC, bx SHALL hold and the state SHALL go to DEC; at bx == 0 in DEC, bx SHALL hold and the state SHALL go to INC. Y axis SHALL behave the same with limit V_VISIBLE-64 (416).
REQ-023 The box SHALL step on every boundary regardless of the active pattern.
REQ-024 While en = 0: both pipeline stages SHALL load blank (RGB 000, syncs 1); frame boundaries SHALL be ignored; frame_cnt, pattern and box SHALL hold.
REQ-025 When en rises, valid output SHALL resume 2 cycles later.
REQ-026 Frame boundary coincident with a visible pixel: the new pattern/box SHALL apply from the next cycle's pixel.

Reset
REQ-027 On rst: RGB SHALL be 000, hsync/vsync SHALL be 1, both pipeline stages SHALL be blank, active pattern SHALL be 0, frame_cnt SHALL be 0, bx = by = 0, both axes SHALL be INC, and the vsync edge register SHALL be 1.
REQ-028 rst SHALL override en, and reset mid-frame SHALL take effect on the next pclk edge with no partial-pixel output.

Structure
REQ-029 A shared package vga_pkg SHALL hold the visible, porch and sync constants (640/16/96/48, 480/10/2/33), the pattern encodings PAT_BARS=0, PAT_CHECK=1, PAT_GRID=2, PAT_BOX=3, and BOX_SIZE=64.
REQ-030 The box position and direction FSM SHALL be a sub-module vga_bounce_box, stepped by a frame-boundary strobe.

Verification
REQ-031 Reset, then pat_sel=0 with a frame boundary, then col=0/row=0 -> RGB 111 two cycles later; col=639 -> RGB 000; col=640 -> RGB 000.
REQ-032 pat_sel changed 0 -> 2 mid-frame -> bars persist until vsync_in falls; next frame col=32/row=7 -> 111, col=33/row=7 -> 001.
REQ-033 pat_sel=1 over 3 frames (frame_cnt=3): col=29/row=0 -> 111 (bit5 of 32 = 1); col=28/row=0 -> 000.
REQ-034 pat_sel=3 for 600 frames -> bx rises to 576, holds one boundary, then decrements; by reaches 416 then reverses; never out of range.
REQ-035 hsync_in pulse for 96 cycles -> hsync output identical pulse delayed exactly 2 cycles.
REQ-036 en dropped mid-line for 5 cycles with a vsync_in fall inside the window -> blank/sync-high output, frame_cnt unchanged; rst asserted mid-frame -> all REQ-027 values next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA pattern generator slice.
//   - 640x480 timing constants (visible / front porch / sync / back porch)
//   - pattern encodings, box size, box direction states
//   - pipeline stage record and helpers for the bar and checker patterns
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE_PIX   = 640;
    localparam int H_FRONT_PORCH   = 16;
    localparam int H_SYNC_PULSE    = 96;
    localparam int H_BACK_PORCH    = 48;

    localparam int V_VISIBLE_LINES = 480;
    localparam int V_FRONT_PORCH   = 10;
    localparam int V_SYNC_PULSE    = 2;
    localparam int V_BACK_PORCH    = 33;

    localparam int BOX_SIZE        = 64;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_BOX   = 2'd3
    } pat_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    // One pipeline stage: colour plus the syncs that travel alongside it.
    typedef struct packed {
        logic [2:0] rgb;
        logic       hsync;
        logic       vsync;
    } pix_t;

    localparam pix_t PIX_BLANK = '{rgb: 3'b000, hsync: 1'b1, vsync: 1'b1};

    // Bar k = col/80 gets colour 7-k; only meaningful for visible columns.
    function automatic logic [2:0] bar_colour(input logic [9:0] col);
        return 3'(10'd7 - (col / 10'd80));
    endfunction

    // Bit 5 of the 10-bit (carry-discarding) sum col + frame count.
    function automatic logic checker_col_bit(input logic [9:0] col, input logic [7:0] frame_cnt);
        return |(10'(col + {2'b00, frame_cnt}) & 10'h020);
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen_if
// Bundles the timing-generator inputs and the registered video outputs.
//   master : drives en, col_in, row_in, hsync_in, vsync_in, pat_sel;
//            receives red, green, blue, hsync, vsync
//   slave  : the pattern generator (opposite directions)
// ---------------------------------------------------------------------------
interface vga_pattern_gen_if;
    import vga_pkg::*;

    logic       en;
    logic [9:0] col_in;
    logic [9:0] row_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [1:0] pat_sel;
    logic       red;
    logic       green;
    logic       blue;
    logic       hsync;
    logic       vsync;

    modport master (
        output en, col_in, row_in, hsync_in, vsync_in, pat_sel,
        input  red, green, blue, hsync, vsync
    );

    modport slave (
        input  en, col_in, row_in, hsync_in, vsync_in, pat_sel,
        output red, green, blue, hsync, vsync
    );

endinterface

// File: rtl/vga_bounce_box.sv
// ---------------------------------------------------------------------------
// vga_bounce_box
// Position of the 64x64 bouncing box. Each axis has its own INC/DEC
// direction FSM and moves by one pixel per step strobe. On reaching its
// limit (or zero) an axis holds for that step and reverses direction.
// Ports:
//   pclk  in   pixel clock
//   rst   in   synchronous active-high reset (position 0, both axes INC)
//   step  in   one-cycle frame-boundary strobe
//   bx    out  box left column
//   by    out  box top row
// ---------------------------------------------------------------------------
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_PIX,
    parameter int V_VISIBLE = V_VISIBLE_LINES
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam int NUM_AXES = 2;

    // Axis 0 is X, axis 1 is Y.
    logic [NUM_AXES-1:0][9:0] pos;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            localparam logic [9:0] AXIS_LIMIT = (gi == 0) ? 10'(H_VISIBLE - BOX_SIZE)
                                                          : 10'(V_VISIBLE - BOX_SIZE);
            dir_e       dir_reg;
            dir_e       dir_next;
            logic [9:0] pos_reg;
            logic [9:0] pos_next;

            always_ff @(posedge pclk) begin
                if (rst) begin
                    dir_reg <= DIR_INC;
                    pos_reg <= '0;
                end else begin
                    dir_reg <= dir_next;
                    pos_reg <= pos_next;
                end
            end

            // At an end stop the turning step only changes direction, so the
            // box rests one frame against the edge before moving back.
            always_comb begin
                dir_next = dir_reg;
                pos_next = pos_reg;
                if (step) begin
                    case (dir_reg)
                        DIR_INC: begin
                            if (pos_reg == AXIS_LIMIT) dir_next = DIR_DEC;
                            else                       pos_next = pos_reg + 10'd1;
                        end
                        DIR_DEC: begin
                            if (pos_reg == 10'd0) dir_next = DIR_INC;
                            else                  pos_next = pos_reg - 10'd1;
                        end
                        default: ;
                    endcase
                end
            end

            assign pos[gi] = pos_reg;
        end
    endgenerate

    assign bx = pos[0];
    assign by = pos[1];

endmodule

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Test-pattern generator behind a VGA timing generator. Two register stages:
// stage 1 holds the computed colour with its syncs, stage 2 drives the pins,
// so colour and syncs leave exactly two pixel clocks after being sampled.
// Patterns: colour bars, scrolling checker, grid, bouncing red box. The
// pattern select, frame counter and box position change only on a falling
// edge of vsync_in (the frame boundary) while en is high.
// Ports:
//   pclk  in  pixel clock
//   rst   in  synchronous active-high reset, overrides en
//   vga   slave modport of vga_pattern_gen_if
//         (en, col_in, row_in, hsync_in, vsync_in, pat_sel in;
//          red, green, blue, hsync, vsync out, all registered)
// ---------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_PIX,
    parameter int V_VISIBLE = V_VISIBLE_LINES
) (
    input  logic              pclk,
    input  logic              rst,
    vga_pattern_gen_if.slave  vga
);

    localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE - 1);
    localparam logic [10:0] BOX_SPAN = 11'(BOX_SIZE);

    logic       vs_prev_reg;
    logic       frame_tick;
    pat_e       pat_reg;
    logic [7:0] frame_cnt_reg;
    logic [9:0] box_x;
    logic [9:0] box_y;
    pix_t       stage1_reg;
    pix_t       stage2_reg;
    pix_t       stage1_next;
    logic       visible;
    logic       grid_line;
    logic       in_box;
    logic [2:0] rgb_next;

    // The edge register keeps tracking vsync_in while en is low, so a fall
    // that happens during the gap is consumed rather than fired late.
    always_ff @(posedge pclk) begin
        if (rst) vs_prev_reg <= 1'b1;
        else     vs_prev_reg <= vga.vsync_in;
    end

    assign frame_tick = vga.en && vs_prev_reg && !vga.vsync_in;

    always_ff @(posedge pclk) begin
        if (rst) begin
            pat_reg       <= PAT_BARS;
            frame_cnt_reg <= 8'd0;
        end else if (frame_tick) begin
            pat_reg       <= pat_e'(vga.pat_sel);
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    vga_bounce_box #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE)
    ) u_bounce_box (
        .pclk (pclk),
        .rst  (rst),
        .step (frame_tick),
        .bx   (box_x),
        .by   (box_y)
    );

    // Colour uses the pattern/box registers as they stand this cycle; an
    // update on a boundary cycle therefore shows from the following pixel.
    always_comb begin
        visible   = (vga.col_in <= H_LAST) && (vga.row_in <= V_LAST);
        grid_line = (vga.col_in[4:0] == 5'd0) || (vga.row_in[4:0] == 5'd0) ||
                    (vga.col_in == H_LAST)    || (vga.row_in == V_LAST);
        // 11-bit compare so bx+64 cannot wrap.
        in_box    = ({1'b0, vga.col_in} >= {1'b0, box_x}) &&
                    ({1'b0, vga.col_in} <  ({1'b0, box_x} + BOX_SPAN)) &&
                    ({1'b0, vga.row_in} >= {1'b0, box_y}) &&
                    ({1'b0, vga.row_in} <  ({1'b0, box_y} + BOX_SPAN));

        rgb_next = 3'b000;
        if (visible) begin
            case (pat_reg)
                PAT_BARS:  rgb_next = bar_colour(vga.col_in);
                PAT_CHECK: rgb_next = (checker_col_bit(vga.col_in, frame_cnt_reg) ^ vga.row_in[5])
                                      ? 3'b111 : 3'b000;
                PAT_GRID:  rgb_next = grid_line ? 3'b111 : 3'b001;
                PAT_BOX:   rgb_next = in_box ? 3'b100 : 3'b000;
                default:   rgb_next = 3'b000;
            endcase
        end

        stage1_next = '{rgb: rgb_next, hsync: vga.hsync_in, vsync: vga.vsync_in};
    end

    // With en low both stages flush to blank, so valid video returns two
    // clocks after en rises.
    always_ff @(posedge pclk) begin
        if (rst || !vga.en) begin
            stage1_reg <= PIX_BLANK;
            stage2_reg <= PIX_BLANK;
        end else begin
            stage1_reg <= stage1_next;
            stage2_reg <= stage1_reg;
        end
    end

    assign {vga.red, vga.green, vga.blue} = stage2_reg.rgb;
    assign vga.hsync = stage2_reg.hsync;
    assign vga.vsync = stage2_reg.vsync;

endmodule
